// File: rtl/sd_cmd_pkg.sv
// sd_cmd_pkg: shared constants, state encoding and status helper for the SD
// command serialiser (sd_cmd_serial_host) and its CRC7 sub-block (sd_crc7).
package sd_cmd_pkg;

  // CRC7 generator x^7 + x^3 + 1 (the x^7 term is implicit in the shift)
  localparam logic [6:0] CRC7_POLY = 7'h09;

  // Response size codes carried in settings[6:0]
  localparam logic [6:0] RSP_NONE  = 7'd0;
  localparam logic [6:0] RSP_SMALL = 7'd40;
  localparam logic [6:0] RSP_BIG   = 7'd127;

  // serial_status bit positions
  localparam int unsigned ST_DATA_AVAIL = 6;
  localparam int unsigned ST_CRC_VALID  = 5;
  localparam int unsigned ST_TIMEOUT    = 4;
  localparam int unsigned ST_TX_DONE    = 0;

  // Frame geometry, in bits
  localparam logic [7:0] CMD_BITS          = 8'd40;
  localparam logic [7:0] CMD_FRAME_LEN     = 8'd48;
  localparam logic [7:0] RSP_BIG_FRAME_LEN = 8'd136;
  localparam logic [7:0] TX_CRC_LAST       = 8'd46;

  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    DELAY  = 6'b000010,
    WRITE  = 6'b000100,
    TURN   = 6'b001000,
    READ   = 6'b010000,
    FINISH = 6'b100000
  } state_e;

  function automatic logic [7:0] make_status(input logic data, input logic crc,
                                             input logic tmo, input logic done);
    logic [7:0] s;
    s                = '0;
    s[ST_DATA_AVAIL] = data;
    s[ST_CRC_VALID]  = crc;
    s[ST_TIMEOUT]    = tmo;
    s[ST_TX_DONE]    = done;
    return s;
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: bit-serial CRC7 (x^7 + x^3 + 1, init 0).
//   clk, rst : clock, asynchronous active-high reset
//   en       : shift bit_in into the CRC this cycle
//   clr      : synchronous clear to zero (wins over en)
//   bit_in   : serial data bit, MSB first
//   crc      : current remainder
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       bit_in,
  output logic [6:0] crc
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ ({7{bit_in ^ crc[6]}} & CRC7_POLY);
    end
  end

endmodule

// File: rtl/sd_cmd_serial_host.sv
// sd_cmd_serial_host: accepts a 40-bit command and settings word over a
// req/ack handshake, sends the 48-bit SD command frame (CRC7 appended) on the
// CMD line, captures the card response and returns response plus status over
// a second req/ack handshake. One CMD bit per clk.
//   settings      : [10:8] pre-delay, [7] CRC check, [6:0] response size
//   cmd_in        : {2'b01, index, arg}
//   req_in/ack_out: command handshake (req_in synchronised internally)
//   req_out/ack_in: result handshake (ack_in synchronised internally)
//   cmd_out       : first 40 response bits, start bit at [39]
//   serial_status : [6] data avail, [5] crc valid, [4] timeout, [0] tx done
//   go_idle_i     : abort to IDLE, highest priority
//   sd_cmd_i/o/oe : CMD pad
// Macro SD_CMD_RSP_CRC_EN enables CRC checking of short responses.
module sd_cmd_serial_host
  import sd_cmd_pkg::*;
#(
  parameter int unsigned NCR_TIMEOUT = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] settings,
  input  logic [39:0] cmd_in,
  input  logic        req_in,
  output logic        ack_out,
  output logic        req_out,
  input  logic        ack_in,
  output logic [39:0] cmd_out,
  output logic [7:0]  serial_status,
  input  logic        go_idle_i,
  input  logic        sd_cmd_i,
  output logic        sd_cmd_o,
  output logic        sd_cmd_oe
);

  localparam int unsigned NCR_W = $clog2(NCR_TIMEOUT + 1);

  state_e                 state;
  logic [SYNC_STAGES-1:0] req_sync;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   req_s;
  logic                   ack_s;
  logic                   req_prev;
  logic [39:0]            tx_shift;
  logic [2:0]             dly_cnt;
  logic [7:0]             bit_cnt;
  logic [NCR_W-1:0]       ncr_cnt;
  logic [6:0]             rsp_size_q;
  logic                   crc_chk_q;
  logic                   acked;
  logic [6:0]             tx_crc;
  logic                   tx_crc_en;
  logic                   tx_crc_clr;
  logic [2:0]             crc_idx;
  logic [7:0]             rx_last;
  logic                   crc_ok;
  logic                   unused_cfg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_sync <= '0;
      ack_sync <= '0;
    end else begin
      req_sync <= {req_sync[SYNC_STAGES-2:0], req_in};
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_in};
    end
  end

  assign req_s = req_sync[SYNC_STAGES-1];
  assign ack_s = ack_sync[SYNC_STAGES-1];

  always_comb begin
    tx_crc_clr = (state == IDLE);
    tx_crc_en  = ((state == DELAY) && (dly_cnt == '0)) ||
                 ((state == WRITE) && (bit_cnt < CMD_BITS));
    crc_idx    = 3'(TX_CRC_LAST - bit_cnt);
    rx_last    = (rsp_size_q == RSP_BIG) ? (RSP_BIG_FRAME_LEN - 8'd1)
                                         : (CMD_FRAME_LEN - 8'd1);
  end

  sd_crc7 u_tx_crc (
    .clk    (clk),
    .rst    (rst),
    .en     (tx_crc_en),
    .clr    (tx_crc_clr),
    .bit_in (tx_shift[39]),
    .crc    (tx_crc)
  );

`ifdef SD_CMD_RSP_CRC_EN
  logic [6:0] rx_crc;
  logic [6:0] rsp_crc;
  logic       rx_crc_en;
  logic       rx_crc_clr;

  // The start bit is fed too; a leading zero leaves a zero-init CRC unchanged.
  always_comb begin
    rx_crc_clr = (state == IDLE);
    rx_crc_en  = ((state == TURN) && !sd_cmd_i) ||
                 ((state == READ) && (bit_cnt < CMD_BITS));
    crc_ok     = !crc_chk_q || (rx_crc == rsp_crc);
  end

  sd_crc7 u_rx_crc (
    .clk    (clk),
    .rst    (rst),
    .en     (rx_crc_en),
    .clr    (rx_crc_clr),
    .bit_in (sd_cmd_i),
    .crc    (rx_crc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_crc <= '0;
    end else if ((state == READ) && (bit_cnt >= CMD_BITS) &&
                 (bit_cnt < (CMD_FRAME_LEN - 8'd1))) begin
      rsp_crc <= {rsp_crc[5:0], sd_cmd_i};
    end
  end

  assign unused_cfg = ^settings[15:11];
`else
  assign crc_ok     = 1'b1;
  assign unused_cfg = ^{settings[15:11], crc_chk_q};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      sd_cmd_o      <= 1'b1;
      sd_cmd_oe     <= 1'b0;
      ack_out       <= 1'b0;
      req_out       <= 1'b0;
      cmd_out       <= '0;
      serial_status <= '0;
      tx_shift      <= '0;
      dly_cnt       <= '0;
      bit_cnt       <= '0;
      ncr_cnt       <= '0;
      rsp_size_q    <= '0;
      crc_chk_q     <= 1'b0;
      acked         <= 1'b0;
      req_prev      <= 1'b0;
    end else begin
      req_prev <= req_s;
      if (go_idle_i) begin
        state         <= IDLE;
        sd_cmd_oe     <= 1'b0;
        sd_cmd_o      <= 1'b1;
        req_out       <= 1'b0;
        ack_out       <= 1'b1;
        serial_status <= '0;
        acked         <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            ack_out   <= 1'b1;
            sd_cmd_oe <= 1'b0;
            sd_cmd_o  <= 1'b1;
            acked     <= 1'b0;
            if (req_s && !req_prev) begin
              tx_shift   <= cmd_in;
              dly_cnt    <= settings[10:8];
              crc_chk_q  <= settings[7];
              rsp_size_q <= settings[6:0];
              cmd_out    <= '0;
              ack_out    <= 1'b0;
              sd_cmd_oe  <= 1'b1;
              state      <= DELAY;
            end
          end
          DELAY: begin
            if (dly_cnt == '0) begin
              sd_cmd_o <= tx_shift[39];
              tx_shift <= {tx_shift[38:0], 1'b0};
              bit_cnt  <= 8'd1;
              state    <= WRITE;
            end else begin
              dly_cnt <= dly_cnt - 3'd1;
            end
          end
          WRITE: begin
            bit_cnt <= bit_cnt + 8'd1;
            if (bit_cnt < CMD_BITS) begin
              sd_cmd_o <= tx_shift[39];
              tx_shift <= {tx_shift[38:0], 1'b0};
            end else if (bit_cnt < (CMD_FRAME_LEN - 8'd1)) begin
              sd_cmd_o <= tx_crc[crc_idx];
            end else if (bit_cnt == (CMD_FRAME_LEN - 8'd1)) begin
              sd_cmd_o <= 1'b1;
            end else begin
              sd_cmd_oe <= 1'b0;
              sd_cmd_o  <= 1'b1;
              ncr_cnt   <= '0;
              if (rsp_size_q == RSP_NONE) begin
                serial_status <= make_status(1'b1, 1'b1, 1'b0, 1'b1);
                req_out       <= 1'b1;
                state         <= FINISH;
              end else begin
                state <= TURN;
              end
            end
          end
          TURN: begin
            if (!sd_cmd_i) begin
              cmd_out <= {cmd_out[38:0], 1'b0};
              bit_cnt <= 8'd1;
              state   <= READ;
            end else if (ncr_cnt == NCR_W'(NCR_TIMEOUT - 1)) begin
              serial_status <= make_status(1'b0, 1'b0, 1'b1, 1'b1);
              req_out       <= 1'b1;
              state         <= FINISH;
            end else begin
              ncr_cnt <= ncr_cnt + 1'b1;
            end
          end
          READ: begin
            bit_cnt <= bit_cnt + 8'd1;
            if (bit_cnt < CMD_BITS) begin
              cmd_out <= {cmd_out[38:0], sd_cmd_i};
            end
            if (bit_cnt == rx_last) begin
              serial_status <= (rsp_size_q == RSP_BIG)
                             ? make_status(1'b1, 1'b1, 1'b0, 1'b1)
                             : make_status(1'b1, crc_ok, 1'b0, 1'b1);
              req_out       <= 1'b1;
              state         <= FINISH;
            end
          end
          FINISH: begin
            if (!acked) begin
              if (ack_s) begin
                req_out <= 1'b0;
                acked   <= 1'b1;
              end
            end else if (!ack_s) begin
              serial_status <= '0;
              ack_out       <= 1'b1;
              state         <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_serial_host.sv
module tb_sd_cmd_serial_host;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] settings;
  logic [39:0] cmd_in;
  logic        req_in;
  logic        ack_out;
  logic        req_out;
  logic        ack_in;
  logic [39:0] cmd_out;
  logic [7:0]  serial_status;
  logic        go_idle_i;
  logic        sd_cmd_i;
  logic        sd_cmd_o;
  logic        sd_cmd_oe;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  sd_cmd_serial_host #(.NCR_TIMEOUT(64), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .settings      (settings),
    .cmd_in        (cmd_in),
    .req_in        (req_in),
    .ack_out       (ack_out),
    .req_out       (req_out),
    .ack_in        (ack_in),
    .cmd_out       (cmd_out),
    .serial_status (serial_status),
    .go_idle_i     (go_idle_i),
    .sd_cmd_i      (sd_cmd_i),
    .sd_cmd_o      (sd_cmd_o),
    .sd_cmd_oe     (sd_cmd_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Remainder of M(x)*x^7 divided by x^7+x^3+1, by polynomial long division.
  function automatic logic [6:0] ref_crc7(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  // Presents a command, waits for acceptance and measures the pre-delay.
  // Returns with the first frame bit (start bit) on the line.
  task automatic start_cmd(input logic [39:0] cmd, input logic [15:0] set, output logic ok);
    int unsigned k;
    int unsigned n;
    ok       = 1'b1;
    cmd_in   = cmd;
    settings = set;
    req_in   = 1'b1;
    k = 0;
    while (!sd_cmd_oe && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!sd_cmd_oe) begin
      check("accept_timeout", 64'd0, 64'd1);
      ok = 1'b0;
      return;
    end
    check("ack_busy", ack_out, 1'b0);
    n = 0;
    while (sd_cmd_oe && sd_cmd_o && n < 16) begin
      n++;
      @(negedge clk);
    end
    check("pre_delay", n, set[10:8] + 1);
  endtask

  task automatic read_frame(output logic [47:0] fr);
    fr = '0;
    for (int i = 0; i < 48; i++) begin
      fr = {fr[46:0], sd_cmd_o};
      @(negedge clk);
    end
    check("oe_release", sd_cmd_oe, 1'b0);
  endtask

  // gap < 0 means the card never answers.
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [2:0] pre,
                         input logic [6:0] size, input logic chk, input int gap,
                         input logic corrupt, input logic hold_req, input logic [39:0] r40);
    logic [39:0]  cmd;
    logic [15:0]  set;
    logic [47:0]  fr;
    logic [135:0] rsp;
    logic [6:0]   rc;
    logic [7:0]   exp_st;
    logic [39:0]  exp_co;
    logic         ok;
    logic         crc_valid;
    int unsigned  len;
    int unsigned  k;
    cmd = {2'b01, idx, arg};
    set = {3'b000, 2'($urandom_range(0, 3)), pre, chk, size};
    start_cmd(cmd, set, ok);
    if (!ok) begin
      req_in = 1'b0;
      return;
    end
    if (!hold_req) req_in = 1'b0;
    read_frame(fr);
    check("tx_frame", fr, {cmd, ref_crc7(cmd), 1'b1});
    if (size == 7'd0) begin
      exp_st = 8'h61;
      exp_co = '0;
    end else if (gap < 0) begin
      k = 0;
      while (!req_out && k < 100) begin
        @(negedge clk);
        k++;
      end
      check("ncr_timeout_cycles", k, 64);
      exp_st = 8'h11;
      exp_co = '0;
    end else begin
      rc = ref_crc7(r40);
      if (corrupt) rc = rc ^ (7'b1 << $urandom_range(0, 6));
      if (size == 7'd127) begin
        len = 136;
        rsp = {r40, $urandom, $urandom, $urandom};
      end else begin
        len = 48;
        rsp = {r40, rc, 1'b1, 88'b0};
      end
      repeat (gap) @(negedge clk);
      for (int i = 0; i < len; i++) begin
        sd_cmd_i = rsp[135 - i];
        @(negedge clk);
      end
      sd_cmd_i = 1'b1;
`ifdef SD_CMD_RSP_CRC_EN
      crc_valid = !chk || !corrupt || (size == 7'd127);
`else
      crc_valid = 1'b1;
`endif
      exp_st = 8'h41 | (crc_valid ? 8'h20 : 8'h00);
      exp_co = r40;
    end
    check("req_out_up", req_out, 1'b1);
    check("cmd_out", cmd_out, exp_co);
    check("status", serial_status, exp_st);
    repeat ($urandom_range(1, 4)) @(negedge clk);
    check("req_hold", req_out, 1'b1);
    ack_in = 1'b1;
    k = 0;
    while (req_out && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("req_drop", req_out, 1'b0);
    check("status_stable", serial_status, exp_st);
    ack_in = 1'b0;
    k = 0;
    while (!ack_out && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("back_idle", ack_out, 1'b1);
    check("status_clear", serial_status, 8'h00);
    if (hold_req) begin
      repeat (12) @(negedge clk);
      check("no_restart", {ack_out, sd_cmd_oe}, 2'b10);
      req_in = 1'b0;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic go_idle_test();
    logic        ok;
    int unsigned bad;
    start_cmd({2'b01, 6'd17, 32'h0}, {3'b0, 2'b10, 3'd1, 1'b1, 7'd40}, ok);
    req_in = 1'b0;
    if (!ok) return;
    repeat (20) @(negedge clk);
    go_idle_i = 1'b1;
    @(negedge clk);
    go_idle_i = 1'b0;
    check("abort_oe", sd_cmd_oe, 1'b0);
    check("abort_o", sd_cmd_o, 1'b1);
    check("abort_ack", ack_out, 1'b1);
    check("abort_req", req_out, 1'b0);
    bad = 0;
    repeat (80) begin
      @(negedge clk);
      if (req_out || sd_cmd_oe || serial_status != 8'h00) bad++;
    end
    check("abort_quiet", bad, 0);
  endtask

  task automatic reset_test();
    logic        ok;
    logic [39:0] cmd;
    logic [47:0] fr;
    cmd = {2'b01, 6'd8, 32'h000001AA};
    start_cmd(cmd, {3'b0, 2'b01, 3'($urandom_range(0, 7)), 1'b1, 7'd127}, ok);
    req_in = 1'b0;
    if (!ok) return;
    read_frame(fr);
    check("cmd8_frame", fr, 48'h48000001AA87);
    sd_cmd_i = 1'b0;
    @(negedge clk);
    repeat (30) begin
      sd_cmd_i = 1'($urandom);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("rst_mid_o", sd_cmd_o, 1'b1);
    check("rst_mid_oe", sd_cmd_oe, 1'b0);
    check("rst_mid_ack", ack_out, 1'b0);
    check("rst_mid_req", req_out, 1'b0);
    check("rst_mid_cmd_out", cmd_out, 40'h0);
    check("rst_mid_status", serial_status, 8'h00);
    sd_cmd_i = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_idle", ack_out, 1'b1);
  endtask

  initial begin
    logic [6:0] sz;
    int         gap;
    rst       = 1'b1;
    settings  = '0;
    cmd_in    = '0;
    req_in    = 1'b0;
    ack_in    = 1'b0;
    go_idle_i = 1'b0;
    sd_cmd_i  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_o", sd_cmd_o, 1'b1);
    check("rst_oe", sd_cmd_oe, 1'b0);
    check("rst_ack", ack_out, 1'b0);
    check("rst_req", req_out, 1'b0);
    check("rst_cmd_out", cmd_out, 40'h0);
    check("rst_status", serial_status, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ack", ack_out, 1'b1);

    run_cmd(6'd0, 32'h0, 3'd0, 7'd0, 1'b1, 0, 1'b0, 1'b0, 40'h0);
    run_cmd(6'd17, 32'h0, 3'd2, 7'd40, 1'b1, 5, 1'b0, 1'b0, 40'h1100000900);
    run_cmd(6'd17, 32'h0, 3'd0, 7'd40, 1'b1, 5, 1'b1, 1'b0, 40'h1100000900);
    run_cmd(6'd17, 32'h0, 3'd0, 7'd40, 1'b0, 3, 1'b1, 1'b0, 40'h1100000900);
    run_cmd(6'd17, 32'h0, 3'd1, 7'd40, 1'b1, -1, 1'b0, 1'b1, 40'h0);
    go_idle_test();

    for (int t = 0; t < 20; t++) begin
      case ($urandom_range(0, 2))
        0:       sz = 7'd0;
        1:       sz = 7'd40;
        default: sz = 7'd127;
      endcase
      gap = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 20));
      run_cmd(6'($urandom), $urandom, 3'($urandom), sz, 1'($urandom), gap,
              ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
              {1'b0, 7'($urandom), $urandom});
    end

    reset_test();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
